// File: rtl/ma_pkg.sv
// ma_pkg -- shared constants and width helpers for the power-of-two moving average.
//   sum_width     : running-sum width (sample width plus growth for the largest window)
//   len_sel_width : width of the window-exponent select bus
//   buf_depth     : circular buffer depth for a given maximum window exponent
package ma_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 16;
  localparam int DEFAULT_LOG2_MAX_LEN = 5;
  localparam int DEFAULT_DEPTH        = 1 << DEFAULT_LOG2_MAX_LEN;

  // A sum of 2^log2_max_len samples grows by log2_max_len bits, so it can never overflow.
  function automatic int sum_width(input int data_width, input int log2_max_len);
    return data_width + log2_max_len;
  endfunction

  // Wide enough to encode exponents 0..log2_max_len.
  function automatic int len_sel_width(input int log2_max_len);
    return (log2_max_len < 1) ? 1 : $clog2(log2_max_len + 1);
  endfunction

  function automatic int buf_depth(input int log2_max_len);
    return 1 << log2_max_len;
  endfunction

endpackage

// File: rtl/ma_delay_ram.sv
// ma_delay_ram -- sample history for the moving average.
// Single write port, asynchronous read, no reset.
// Ports:
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : sample to store
//   i_raddr : read address (combinational read)
//   o_rdata : stored sample at i_raddr
module ma_delay_ram
  import ma_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = DEFAULT_DEPTH,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset so it maps onto plain RAM; stale entries are
  // never used because the reader masks them until the window has refilled.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read happens before the same-edge write, so the reader sees the old value.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/moving_average_pow2.sv
// moving_average_pow2 -- running mean over the last 2^k accepted samples.
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   ce         : sample enable, din accepted when high
//   din        : signed input sample
//   len_sel    : requested window exponent k (clamped to LOG2_MAX_LEN)
//   dout       : signed rounded mean, held between strobes
//   dout_valid : one-cycle strobe, two cycles after an accept that completes a full window
//   busy_fill  : high while fewer than 2^k samples have been accepted since the last flush
module moving_average_pow2
  import ma_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int LOG2_MAX_LEN = DEFAULT_LOG2_MAX_LEN
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    ce,
  input  logic signed [DATA_WIDTH-1:0]            din,
  input  logic [len_sel_width(LOG2_MAX_LEN)-1:0]  len_sel,
  output logic signed [DATA_WIDTH-1:0]            dout,
  output logic                                    dout_valid,
  output logic                                    busy_fill
);

  localparam int SW    = sum_width(DATA_WIDTH, LOG2_MAX_LEN);
  localparam int LSW   = len_sel_width(LOG2_MAX_LEN);
  localparam int DEPTH = buf_depth(LOG2_MAX_LEN);
  localparam int AW    = LOG2_MAX_LEN;
  localparam int FW    = LOG2_MAX_LEN + 1;  // holds fill counts 0..2^LOG2_MAX_LEN

  localparam logic [LSW-1:0] K_MAX = LSW'(LOG2_MAX_LEN);

  // Control state
  logic [LSW-1:0]              r_k_cur;
  logic signed [SW-1:0]        r_sum;
  logic [FW-1:0]               r_fill_cnt;
  logic [AW-1:0]               r_wr_ptr;

  // Output pipeline: s1 = sum updated, s2 = mean rounded, then the output register
  logic                        r_s1_valid;
  logic                        r_s2_valid;
  logic signed [DATA_WIDTH-1:0] r_mean;
  logic signed [DATA_WIDTH-1:0] r_dout;
  logic                        r_dout_valid;

  logic [LSW-1:0]              w_k_req;
  logic                        w_len_change;
  logic                        w_accept;
  logic [FW-1:0]               w_len;
  logic                        w_window_full;
  logic [AW-1:0]               w_rd_addr;
  logic [DATA_WIDTH-1:0]       w_ram_rdata;
  logic signed [DATA_WIDTH-1:0] w_oldest;
  logic signed [SW-1:0]        w_sum_next;
  logic [FW-1:0]               w_fill_next;
  logic signed [SW-1:0]        w_half;

  assign w_k_req      = (len_sel > K_MAX) ? K_MAX : len_sel;
  assign w_len_change = (w_k_req != r_k_cur);
  // A sample offered on a length-change edge is dropped along with the history.
  assign w_accept     = ce & ~w_len_change;

  assign w_len         = {{(FW-1){1'b0}}, 1'b1} << r_k_cur;
  assign w_window_full = (r_fill_cnt == w_len);
  // With k = LOG2_MAX_LEN the low bits of w_len are zero, so this reads the
  // slot about to be overwritten, which is exactly the sample leaving the window.
  assign w_rd_addr     = r_wr_ptr - w_len[AW-1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_oldest    = '0;
    w_fill_next = r_fill_cnt;
    if (w_window_full) begin
      w_oldest = $signed(w_ram_rdata);
    end else begin
      w_fill_next = r_fill_cnt + FW'(1);
    end
    w_sum_next = r_sum + SW'(din) - SW'(w_oldest);
  end

  // Rounding constant 2^(k-1), zero when k = 0.
  assign w_half = (SW'(1) << r_k_cur) >> 1;

  ma_delay_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_delay_ram (
    .clk     (clk),
    .i_we    (w_accept & ~rst),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k_cur      <= w_k_req;
      r_sum        <= '0;
      r_fill_cnt   <= '0;
      r_wr_ptr     <= '0;
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_mean       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (w_len_change) begin
      // Flush: new window length, empty history, nothing in flight. dout holds.
      r_k_cur      <= w_k_req;
      r_sum        <= '0;
      r_fill_cnt   <= '0;
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      if (ce) begin
        r_sum      <= w_sum_next;
        r_fill_cnt <= w_fill_next;
        r_wr_ptr   <= r_wr_ptr + AW'(1);
      end
      r_s1_valid <= ce & (w_fill_next == w_len);

      // Arithmetic shift of a signed sum gives floor division; adding half first
      // turns it into round-half-up. The mean always fits DATA_WIDTH.
      if (r_s1_valid) r_mean <= DATA_WIDTH'((r_sum + w_half) >>> r_k_cur);
      r_s2_valid <= r_s1_valid;

      if (r_s2_valid) r_dout <= r_mean;
      r_dout_valid <= r_s2_valid;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy_fill  = (r_fill_cnt < w_len);

endmodule

// File: tb/tb_moving_average_pow2.sv
// tb_moving_average_pow2 -- scoreboard bench for moving_average_pow2.
// Stimulus pushes the hand-computed mean and the cycle it must appear on;
// a negedge monitor pops and compares on every dout_valid strobe.
module tb_moving_average_pow2;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ce;
  logic signed [DW-1:0] din;
  logic [2:0]           len_sel;
  logic signed [DW-1:0] dout;
  logic                 dout_valid;
  logic                 busy_fill;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  moving_average_pow2 #(
    .DATA_WIDTH   (16),
    .LOG2_MAX_LEN (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .din        (din),
    .len_sel    (len_sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy_fill  (busy_fill)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of stimulus. When push is set, the accept on the coming
  // edge must produce a strobe carrying val two edges later.
  task automatic step(input logic c, input int d, input logic push, input int val);
    exp_t e;
    if (push) begin
      e.val = val;
      e.cyc = cyc + 3;
      exp_q.push_back(e);
    end
    ce  = c;
    din = DW'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 1'b0, 0);
  endtask

  task automatic set_len(input int v);
    len_sel = 3'(v);
    idle(1);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (dout_valid === 1'b1) begin
      check("strobe_expected", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dout", dout, e.val);
        check("latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ce = 1'b0; din = '0; len_sel = 3'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_busy_fill", busy_fill, 1);
    rst = 1'b0;

    // Window 8, constant 100
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 100, i == 8, 100);
      if (i == 7) check("busy_before_full_L8", busy_fill, 1);
    end
    check("busy_after_full_L8", busy_fill, 0);
    idle(4);
    check("dout_hold", dout, 100);
    check("dout_valid_idle", dout_valid, 0);

    // Window 4, ramp 1..5: 10/4 -> 3, 14/4 -> 4
    set_len(2);
    check("busy_after_flush", busy_fill, 1);
    step(1'b1, 1, 1'b0, 0);
    step(1'b1, 2, 1'b0, 0);
    step(1'b1, 3, 1'b0, 0);
    step(1'b1, 4, 1'b1, 3);
    step(1'b1, 5, 1'b1, 4);
    idle(4);

    // Window 2, negative rounding and most-negative input
    set_len(1);
    step(1'b1, -3, 1'b0, 0);
    step(1'b1, -2, 1'b1, -2);
    step(1'b1, -32768, 1'b1, -16385);
    step(1'b1, -32768, 1'b1, -32768);
    idle(4);

    // Window 1, output is the sample itself
    set_len(0);
    step(1'b1, 7, 1'b1, 7);
    step(1'b1, -5, 1'b1, -5);
    idle(4);

    // Window 32, full-scale positive, ce every third cycle, pointer wraps
    set_len(5);
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 32767, i >= 32, 32767);
      if (i == 31) check("busy_before_full_L32", busy_fill, 1);
      if (i == 32) check("busy_after_full_L32", busy_fill, 0);
      idle(2);
    end
    idle(4);

    // Length change with simultaneous ce: the sample is dropped
    set_len(3);
    for (int i = 1; i <= 5; i++) step(1'b1, 10, 1'b0, 0);
    len_sel = 3'd2;
    step(1'b1, 999, 1'b0, 0);
    check("busy_after_flush_ce", busy_fill, 1);
    for (int i = 1; i <= 4; i++) step(1'b1, 20, i == 4, 20);
    idle(4);

    // len_sel above the maximum clamps to 32; switching 7 -> 5 is no change
    len_sel = 3'd7;
    idle(1);
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 5, i == 32, 5);
      if (i == 31) check("busy_clamped_31", busy_fill, 1);
    end
    len_sel = 3'd5;
    step(1'b1, 5, 1'b1, 5);
    idle(4);

    // Reset mid-window discards history; rst dominates ce
    set_len(3);
    for (int i = 1; i <= 5; i++) step(1'b1, 50, 1'b0, 0);
    rst = 1'b1;
    step(1'b1, 999, 1'b0, 0);
    rst = 1'b0;
    check("midrst_dout", dout, 0);
    check("midrst_dout_valid", dout_valid, 0);
    check("midrst_busy_fill", busy_fill, 1);
    for (int i = 1; i <= 8; i++) step(1'b1, 60, i == 8, 60);
    idle(4);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/moving_average_pow2.md
MOVING_AVERAGE_POW2 -- requirements
Module: moving_average_pow2

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, signed sample width of din and dout.
REQ-002 Parameter: LOG2_MAX_LEN, default 5, log2 of maximum window length (max window 32).
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: ce  input  1  sample enable; din is accepted only on cycles with ce=1.
REQ-006 Port: din  input  DATA_WIDTH  signed input sample.
REQ-007 Port: len_sel  input  ceil(log2(LOG2_MAX_LEN+1))  requested window exponent k, window L=2^k.
REQ-008 Port: dout  output  DATA_WIDTH  signed rounded window mean.
REQ-009 Port: dout_valid  output  1  one-cycle strobe marking a new valid dout.
REQ-010 Port: busy_fill  output  1  high while the window holds fewer than L accepted samples.

Function
REQ-011 Block SHALL register len_sel into k_cur; len_sel values above LOG2_MAX_LEN SHALL clamp to LOG2_MAX_LEN.
REQ-012 Block SHALL store accepted samples in a circular buffer of depth 2^LOG2_MAX_LEN; write pointer increments on each accepted sample, wrapping from 2^LOG2_MAX_LEN-1 to 0.
REQ-013 On accept, oldest = buffer[wr_ptr - L] (modulo depth), read before overwrite; oldest SHALL be treated as 0 while fill_cnt < L.
REQ-014 Running sum width SHALL be DATA_WIDTH+LOG2_MAX_LEN signed; on accept, sum <= sum + din - oldest; no overflow possible.
REQ-015 fill_cnt SHALL count accepted samples, saturating at L; busy_fill = (fill_cnt < L).
REQ-016 Output stage: for k>0, dout = (sum + 2^(k-1)) >>> k (arithmetic, round-half-up); for k=0, dout = sum; result always fits DATA_WIDTH, no saturation logic.
REQ-017 Latency: dout/dout_valid SHALL update exactly 2 clk cycles after the accepting ce cycle, independent of ce in the intervening cycle.
REQ-018 dout_valid SHALL pulse for one cycle per accepted sample whose window was full (fill_cnt reached L including that sample); otherwise stays low.
REQ-019 dout SHALL hold its last value between strobes.
REQ-020 Length change: when clamped len_sel differs from k_cur, on that edge block SHALL load k_cur, clear sum, fill_cnt and in-flight valid; a ce on the same cycle SHALL be discarded.
REQ-021 Buffer contents need not be cleared on flush; REQ-013 zero-masking guarantees correctness.
REQ-022 ce=1 every cycle SHALL be supported at full throughput, no stall.

Reset
REQ-023 When rst=1 at a clock edge: sum=0, fill_cnt=0, wr_ptr=0, k_cur=clamped len_sel, dout=0, dout_valid=0, busy_fill=1, pipeline valid bits=0; rst dominates ce and length change.
REQ-024 Reset asserted mid-window SHALL discard all history; first dout_valid after release requires L new accepted samples.

Structure
REQ-025 Shared package ma_pkg SHALL hold the sum-width and len_sel-width derivation functions and the depth constant.
REQ-026 The circular buffer SHALL be a sub-module ma_delay_ram (single write port, asynchronous read, no reset), instantiated once.
REQ-027 Control (pointer, fill counter, flush) and two-stage arithmetic pipeline SHALL reside in moving_average_pow2.

Verification
REQ-028 Defaults, len_sel=3, ce constant 1, din=100 for 8 samples -> first dout_valid 2 cycles after 8th accept, dout=100; busy_fill falls after 8th accept.
REQ-029 len_sel=2, din sequence 1,2,3,4,5 -> valid outputs 3 (10/4=2.5 rounds to 3) then 4 (14/4=3.5 rounds to 4).
REQ-030 len_sel=1, din=-3,-2 -> dout=-2 ((-5+1)>>>1); din=-32768 repeated -> dout=-32768.
REQ-031 len_sel=5, din=32767 for 40 samples with ce every 3rd cycle -> dout=32767, one strobe per accept from 32nd on, write pointer wraps without glitch.
REQ-032 Mid-stream len_sel 3->2 with simultaneous ce -> that sample dropped, no dout_valid until 4 new accepts; len_sel=7 -> behaves as 5.
REQ-033 rst pulse after 5 of 8 samples -> dout=0, dout_valid=0 next cycle; 8 further samples required before strobe.
